// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 sequential core: walks one instruction
// through FETCH..PCUPD with one-hot stage enables, halting on faults or an instruction budget.
module seq_stage_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MAX_INSTR = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic [3:0]       icode,
    input  logic [1:0]       stat,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
    output logic [1:0]       final_stat,
    output logic             budget_hit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | fetch enabled; faults and halt icode checked
    // DECODE | register read
    // EXEC   | ALU / condition codes
    // MEM    | data memory; non-AOK stat halts here
    // WB     | register write
    // PCUPD  | PC load, instruction retired, budget checked
    // PAUSE  | single-step wait
    // HALT   | sticky until rst
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_PAUSE, S_HALT
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       final_stat_q, final_stat_d;
    logic             budget_hit_q, budget_hit_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] instr_inc;
    logic             budget_reached;

    assign instr_inc      = instr_cnt_q + 1'b1;
    assign budget_reached = (MAX_INSTR != 0) && (instr_inc == CNT_W'(MAX_INSTR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            final_stat_q <= STAT_AOK;
            budget_hit_q <= 1'b0;
            cycle_cnt_q  <= '0;
            instr_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            final_stat_q <= final_stat_d;
            budget_hit_q <= budget_hit_d;
            cycle_cnt_q  <= cycle_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        final_stat_d = final_stat_q;
        budget_hit_d = budget_hit_q;
        instr_cnt_d  = instr_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        exec_en      = 1'b0;
        mem_en       = 1'b0;
        wb_en        = 1'b0;
        pc_en        = 1'b0;

        // Time spent waiting in PAUSE counts as active cycles.
        if (state_q != S_IDLE && state_q != S_HALT) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                if (imem_error) begin
                    state_d      = S_HALT;
                    final_stat_d = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d      = S_HALT;
                    final_stat_d = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d      = S_HALT;
                    final_stat_d = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                exec_en = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                mem_en = 1'b1;
                if (stat != STAT_AOK) begin
                    state_d      = S_HALT;
                    final_stat_d = stat;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb_en   = 1'b1;
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_en       = 1'b1;
                instr_cnt_d = instr_inc;
                if (budget_reached) begin
                    state_d      = S_HALT;
                    final_stat_d = STAT_AOK;
                    budget_hit_d = 1'b1;
                end else if (step_mode) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step || !step_mode) state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign running    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);
    assign final_stat = final_stat_q;
    assign budget_hit = budget_hit_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign instr_cnt  = instr_cnt_q;

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 sequential core. It steps one instruction through fetch, decode, execute, memory, writeback and PC-update, one stage per clk, by driving one-hot stage enables to the datapath blocks. It detects fetch and memory faults, halts on the first non-AOK status, and supports free-run, single-step and instruction-budget stop. It replaces the free-running bench clock loop as the owner of instruction pacing.

Parameters:
CNT_W, 32, width of cycle and retired-instruction counters
MAX_INSTR, 600, retired-instruction budget; 0 disables the budget

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; leaves IDLE and begins fetching
step_mode  in  1  1 = pause after every retired instruction
step  in  1  pulse; releases one instruction from PAUSE
instr_valid  in  1  from fetch; sampled in FETCH
imem_error  in  1  from fetch; sampled in FETCH
icode  in  4  from fetch; sampled in FETCH
stat  in  2  from memory (0 AOK, 1 HLT, 2 ADR, 3 INS); sampled in MEMORY
fetch_en  out  1  fetch stage enable
decode_en  out  1  register-read enable
exec_en  out  1  ALU/condition-code enable
mem_en  out  1  data-memory enable
wb_en  out  1  register write enable
pc_en  out  1  PC register load enable
running  out  1  1 in any stage state or PAUSE
halted  out  1  1 in HALT
final_stat  out  2  status latched on entry to HALT
budget_hit  out  1  1 if HALT was caused by MAX_INSTR
cycle_cnt  out  CNT_W  clk cycles spent outside IDLE/HALT
instr_cnt  out  CNT_W  instructions retired (pc_en cycles)

Behaviour:
- Reset: state IDLE; all enables 0; running 0; halted 0; final_stat 0; budget_hit 0; both counters 0. rst wins over every other input on the same edge, including mid-instruction; no enable is high in the cycle after rst.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, PAUSE, HALT. Exactly one enable is high per stage state (FETCH->fetch_en ... PCUPD->pc_en); none in IDLE, PAUSE or HALT. Enables are Moore outputs decoded from state.
- IDLE: start=1 -> FETCH; else stay.
- FETCH -> DECODE unless a fault: imem_error=1 -> HALT, final_stat=2 (ADR); else instr_valid=0 -> HALT, final_stat=3 (INS). imem_error takes priority.
- FETCH with icode=0 (halt) and no fault -> HALT, final_stat=1 (HLT); no later stage and no PC update.
- DECODE -> EXEC -> MEM unconditionally.
- MEM: stat=0 -> WB; stat!=0 -> HALT, final_stat=stat; WB and PCUPD skipped, so no register or PC state changes.
- WB -> PCUPD.
- PCUPD: instr_cnt increments. If MAX_INSTR!=0 and the incremented count equals MAX_INSTR -> HALT, final_stat=0, budget_hit=1. Else step_mode=1 -> PAUSE. Else -> FETCH.
- PAUSE: step=1 -> FETCH. step_mode dropping to 0 while in PAUSE also -> FETCH. start is ignored.
- HALT: sticky; only rst leaves it. start and step are ignored.
- A full instruction takes 6 cycles FETCH..PCUPD; back-to-back free-run gives one pc_en every 6 cycles.
- cycle_cnt increments every cycle in FETCH..PCUPD and PAUSE. Both counters wrap modulo 2^CNT_W without flagging.
- step or start pulses arriving in states where they are not consumed are dropped, not queued.

Test Plan:
- rst, start pulse, 3 valid non-halt instructions, step_mode=0 -> pc_en at cycles 6, 12, 18 after start; instr_cnt=3; enables are one-hot every cycle.
- Third instruction has icode=0 -> halted=1 after its FETCH cycle; final_stat=1; instr_cnt=2; no decode_en after that FETCH; start is ignored in HALT.
- imem_error=1 and instr_valid=0 together in FETCH -> final_stat=2. instr_valid=0 alone -> final_stat=3. In both cases wb_en and pc_en never assert.
- stat=3 in MEM of the 2nd instruction -> HALT directly from MEM, final_stat=3, instr_cnt=1, no wb_en for that instruction.
- step_mode=1: controller sits in PAUSE after each pc_en; a step pulse yields exactly one more pc_en; two steps 1 cycle apart while not in PAUSE -> the extra step is dropped.
- MAX_INSTR=4, free-run -> HALT after the 4th pc_en with budget_hit=1, final_stat=0, cycle_cnt=24. Asserting rst mid-EXEC -> IDLE, counters 0, no enable the next cycle.
